// File: rtl/run_seq_pkg.sv
// rtl/run_seq_pkg.sv - shared types and constants for the run_sequencer slice
// Purpose: FSM state enum, default parameter values and width helpers.
// Ports: none (package).
package run_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    READ  = 3'd4,
    RESP  = 3'd5
  } run_state_t;

  localparam int DEF_AW         = 8;
  localparam int DEF_DW         = 8;
  localparam int DEF_MAX_OPS    = 4;
  localparam int DEF_BASE_ADDR  = 0;
  localparam int DEF_RES_ADDR   = 2;
  localparam int DEF_START_HOLD = 4;
  localparam int DEF_TIMEOUT    = 1024;

  // $clog2 that never returns 0, so a width derived from it is always legal.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int OP_IDX_W = clog2_min1(DEF_MAX_OPS);

endpackage

// File: rtl/run_timer.sv
// rtl/run_timer.sv - clearable up-counter with terminal-count compare
// Purpose: shared cycle counter for the START hold and the WAIT timeout.
// Ports:
//   i_clk    - clock
//   i_rst_n  - asynchronous active-low reset
//   i_clr    - load zero on the next edge (used on every state entry)
//   i_en     - count up by one
//   i_tc     - terminal count value
//   o_done   - count equals terminal count
module run_timer #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_tc,
  output logic         o_done
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_done = (r_count == i_tc);

endmodule

// File: rtl/run_sequencer.sv
// rtl/run_sequencer.sv - host job sequencer: load operands, start CPU, return result
// Purpose: accepts one job, writes its operands into DM, pulses Cpu_Start,
//   waits for Cpu_Ack (with timeout), reads the result byte and returns it.
// Ports:
//   Clk, Reset                      - clock, asynchronous active-low reset
//   Req_Valid/Req_Ready/Req_Count/Req_Data - job request channel
//   Dm_We/Dm_Addr/Dm_Wdata/Dm_Rdata - CPU data-memory port
//   Cpu_Start/Cpu_Ack               - program launch handshake
//   Rsp_Valid/Rsp_Ready/Rsp_Data/Rsp_Timeout - response channel
//   Busy                            - state is not IDLE
module run_sequencer
  import run_seq_pkg::*;
#(
  parameter int AW         = DEF_AW,
  parameter int DW         = DEF_DW,
  parameter int MAX_OPS    = DEF_MAX_OPS,
  parameter int BASE_ADDR  = DEF_BASE_ADDR,
  parameter int RES_ADDR   = DEF_RES_ADDR,
  parameter int START_HOLD = DEF_START_HOLD,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Req_Valid,
  output logic                  Req_Ready,
  input  logic [2:0]            Req_Count,
  input  logic [MAX_OPS*DW-1:0] Req_Data,
  output logic                  Dm_We,
  output logic [AW-1:0]         Dm_Addr,
  output logic [DW-1:0]         Dm_Wdata,
  input  logic [DW-1:0]         Dm_Rdata,
  output logic                  Cpu_Start,
  input  logic                  Cpu_Ack,
  output logic                  Rsp_Valid,
  input  logic                  Rsp_Ready,
  output logic [DW-1:0]         Rsp_Data,
  output logic                  Rsp_Timeout,
  output logic                  Busy
);

  localparam int IW = clog2_min1(MAX_OPS);
  localparam int CW = clog2_min1(MAX_OPS + 1);
  localparam int TW = clog2_min1((TIMEOUT > START_HOLD) ? TIMEOUT : START_HOLD);

  localparam logic [AW-1:0] LP_BASE    = AW'(BASE_ADDR);
  localparam logic [AW-1:0] LP_RES     = AW'(RES_ADDR);
  localparam logic [TW-1:0] LP_HOLD_TC = TW'(START_HOLD - 1);
  localparam logic [TW-1:0] LP_TO_TC   = TW'(TIMEOUT - 1);

  run_state_t    r_state;
  run_state_t    w_next;
  logic          r_alive;
  logic [DW-1:0] r_ops [MAX_OPS];
  logic [CW-1:0] r_cnt;
  logic [IW-1:0] r_idx;
  logic [DW-1:0] r_result;
  logic          r_timeout;

  logic          w_req_fire;
  logic [CW-1:0] w_req_cnt;
  logic          w_last_op;
  logic          w_tmr_clr;
  logic          w_tmr_en;
  logic [TW-1:0] w_tmr_tc;
  logic          w_tmr_done;

  assign w_req_fire = Req_Valid && Req_Ready;
  assign w_req_cnt  = (int'(Req_Count) > MAX_OPS) ? CW'(MAX_OPS) : CW'(Req_Count);
  assign w_last_op  = ((int'(r_idx) + 1) >= int'(r_cnt));

  // The timer restarts from zero whenever the state changes, so each timed
  // state sees counts 0, 1, 2 ... from its first cycle.
  assign w_tmr_clr = (w_next != r_state);
  assign w_tmr_en  = (r_state == START) || (r_state == WAIT);
  assign w_tmr_tc  = (r_state == WAIT) ? LP_TO_TC : LP_HOLD_TC;

  run_timer #(
    .W (TW)
  ) u_timer (
    .i_clk   (Clk),
    .i_rst_n (Reset),
    .i_clr   (w_tmr_clr),
    .i_en    (w_tmr_en),
    .i_tc    (w_tmr_tc),
    .o_done  (w_tmr_done)
  );

  // State register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_req_fire) begin
          w_next = (w_req_cnt == '0) ? START : LOAD;
        end
      end
      LOAD: begin
        if (w_last_op) w_next = START;
      end
      START: begin
        if (w_tmr_done) w_next = WAIT;
      end
      WAIT: begin
        // Ack takes priority over a timeout landing in the same cycle.
        if (Cpu_Ack) begin
          w_next = READ;
        end else if (w_tmr_done) begin
          w_next = RESP;
        end
      end
      READ: w_next = RESP;
      RESP: begin
        if (Rsp_Ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Output decode from registered state only.
  always_comb begin
    Req_Ready   = 1'b0;
    Dm_We       = 1'b0;
    Dm_Addr     = '0;
    Dm_Wdata    = '0;
    Cpu_Start   = 1'b0;
    Rsp_Valid   = 1'b0;
    Rsp_Data    = '0;
    Rsp_Timeout = 1'b0;
    Busy        = (r_state != IDLE);
    case (r_state)
      IDLE: Req_Ready = r_alive;
      LOAD: begin
        Dm_We    = 1'b1;
        Dm_Addr  = LP_BASE + AW'(r_idx);
        Dm_Wdata = r_ops[r_idx];
      end
      START: Cpu_Start = 1'b1;
      READ:  Dm_Addr = LP_RES;
      RESP: begin
        Rsp_Valid   = 1'b1;
        Rsp_Data    = r_result;
        Rsp_Timeout = r_timeout;
      end
      default: ;
    endcase
  end

  // Holds Req_Ready low until the first edge after reset release.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_alive <= 1'b0;
    end else begin
      r_alive <= 1'b1;
    end
  end

  // Operand, index and result registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < MAX_OPS; i++) begin
        r_ops[i] <= '0;
      end
      r_cnt     <= '0;
      r_idx     <= '0;
      r_result  <= '0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req_fire) begin
            for (int i = 0; i < MAX_OPS; i++) begin
              r_ops[i] <= Req_Data[i*DW +: DW];
            end
            r_cnt     <= w_req_cnt;
            r_idx     <= '0;
            r_result  <= '0;
            r_timeout <= 1'b0;
          end
        end
        LOAD: r_idx <= r_idx + 1'b1;
        WAIT: begin
          if (!Cpu_Ack && w_tmr_done) begin
            r_result  <= '0;
            r_timeout <= 1'b1;
          end
        end
        READ: r_result <= Dm_Rdata;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_run_sequencer.sv
// tb/tb_run_sequencer.sv - self-checking bench for run_sequencer
module tb_run_sequencer;

  localparam int TO   = 20;
  localparam int HOLD = 4;
  localparam int RES  = 2;

  typedef struct {
    int          count;
    logic [31:0] data;
    int          ack_w;      // WAIT cycle (0-based) on which Ack is raised, -1 = never
    bit          ack_start;  // also raise Ack through the whole START window
    int          dm2;        // DM[RES] contents before the job
    int          hold;       // cycles Rsp_Ready stays low in RESP
    int          ed;         // expected Rsp_Data
    int          et;         // expected Rsp_Timeout
  } vec_t;

  logic        Clk;
  logic        Reset;
  logic        Req_Valid;
  logic        Req_Ready;
  logic [2:0]  Req_Count;
  logic [31:0] Req_Data;
  logic        Dm_We;
  logic [7:0]  Dm_Addr;
  logic [7:0]  Dm_Wdata;
  logic [7:0]  Dm_Rdata;
  logic        Cpu_Start;
  logic        Cpu_Ack;
  logic        Rsp_Valid;
  logic        Rsp_Ready;
  logic [7:0]  Rsp_Data;
  logic        Rsp_Timeout;
  logic        Busy;

  logic [7:0]  mem [256];
  logic        tb_we;
  logic [7:0]  tb_addr;
  logic [7:0]  tb_wd;

  int n_chk;
  int n_fail;

  vec_t tbl [7];

  run_sequencer #(
    .AW(8), .DW(8), .MAX_OPS(4), .BASE_ADDR(0), .RES_ADDR(RES),
    .START_HOLD(HOLD), .TIMEOUT(TO)
  ) dut (
    .Clk(Clk), .Reset(Reset),
    .Req_Valid(Req_Valid), .Req_Ready(Req_Ready),
    .Req_Count(Req_Count), .Req_Data(Req_Data),
    .Dm_We(Dm_We), .Dm_Addr(Dm_Addr), .Dm_Wdata(Dm_Wdata), .Dm_Rdata(Dm_Rdata),
    .Cpu_Start(Cpu_Start), .Cpu_Ack(Cpu_Ack),
    .Rsp_Valid(Rsp_Valid), .Rsp_Ready(Rsp_Ready),
    .Rsp_Data(Rsp_Data), .Rsp_Timeout(Rsp_Timeout),
    .Busy(Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Data memory seen by the DUT: combinational read, write on the clock edge.
  assign Dm_Rdata = mem[Dm_Addr];
  always @(posedge Clk) begin
    if (tb_we) mem[tb_addr] <= tb_wd;
    else if (Dm_We) mem[Dm_Addr] <= Dm_Wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic preload(input int a, input int d);
    @(negedge Clk);
    tb_we = 1'b1; tb_addr = 8'(a); tb_wd = 8'(d);
    @(negedge Clk);
    tb_we = 1'b0;
  endtask

  // Reference: result is DM[RES] after the operand writes, or 0 on timeout.
  function automatic void model(input vec_t v, output int d, output int t);
    int n;
    n = (v.count > 4) ? 4 : v.count;
    d = v.dm2;
    for (int i = 0; i < n; i++) begin
      if ((i % 256) == RES) d = int'((v.data >> (8 * i)) & 32'hFF);
    end
    t = 0;
    if (v.ack_w < 0) begin
      d = 0;
      t = 1;
    end
  endfunction

  task automatic run_job(input vec_t v, input int exp_d, input int exp_t);
    int n, cyc, wr_cnt, st_first, st_cnt, rsp_cyc, ack_cyc, k;
    logic [7:0] d0;
    logic       t0;
    n = (v.count > 4) ? 4 : v.count;
    ack_cyc = (v.ack_w >= 0) ? n + HOLD + 1 + v.ack_w : -1;
    preload(RES, v.dm2);
    @(negedge Clk);
    chk("req_ready_idle", Req_Ready, 1);
    Req_Valid = 1'b1; Req_Count = 3'(v.count); Req_Data = v.data;
    @(negedge Clk);
    Req_Valid = 1'b0; Req_Data = $urandom;
    cyc = 1; wr_cnt = 0; st_first = -1; st_cnt = 0; rsp_cyc = -1;
    while (cyc < 200 && rsp_cyc < 0) begin
      if (Dm_We) begin
        k = wr_cnt & 3;
        chk("wr_cycle", cyc, wr_cnt + 1);
        chk("wr_addr", Dm_Addr, wr_cnt);
        chk("wr_data", Dm_Wdata, v.data[8*k +: 8]);
        wr_cnt++;
      end
      if (Cpu_Start) begin
        if (st_first < 0) st_first = cyc;
        st_cnt++;
      end
      if (Rsp_Valid) begin
        rsp_cyc = cyc;
      end else begin
        Cpu_Ack = (cyc == ack_cyc) || (v.ack_start && cyc >= n + 1 && cyc <= n + HOLD);
        @(negedge Clk);
        cyc++;
      end
    end
    Cpu_Ack = 1'b0;
    chk("wr_count", wr_cnt, n);
    chk("start_first", st_first, n + 1);
    chk("start_len", st_cnt, HOLD);
    chk("rsp_cycle", rsp_cyc, (ack_cyc >= 0) ? ack_cyc + 2 : n + HOLD + 1 + TO);
    chk("rsp_data", Rsp_Data, exp_d);
    chk("rsp_timeout", Rsp_Timeout, exp_t);
    d0 = Rsp_Data;
    t0 = Rsp_Timeout;
    for (int h = 0; h < v.hold; h++) begin
      @(negedge Clk);
      chk("bp_valid", Rsp_Valid, 1);
      chk("bp_data", Rsp_Data, d0);
      chk("bp_timeout", Rsp_Timeout, t0);
      chk("bp_req_ready", Req_Ready, 0);
      chk("bp_busy", Busy, 1);
    end
    Rsp_Ready = 1'b1;
    @(negedge Clk);
    Rsp_Ready = 1'b0;
    chk("turn_req_ready", Req_Ready, 1);
    chk("turn_busy", Busy, 0);
    chk("turn_valid", Rsp_Valid, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int   ed, et, w;
    n_chk = 0; n_fail = 0;
    Reset = 1'b0; Req_Valid = 1'b0; Req_Count = '0; Req_Data = '0;
    Cpu_Ack = 1'b0; Rsp_Ready = 1'b0; tb_we = 1'b0; tb_addr = '0; tb_wd = '0;

    tbl[0] = '{count:2, data:32'h0000_1101, ack_w:10, ack_start:0, dm2:8'h00, hold:0, ed:8'h00, et:0};
    tbl[1] = '{count:1, data:32'h0000_0033, ack_w:3,  ack_start:0, dm2:8'hC3, hold:5, ed:8'hC3, et:0};
    tbl[2] = '{count:2, data:32'h0000_6655, ack_w:-1, ack_start:0, dm2:8'h77, hold:2, ed:8'h00, et:1};
    tbl[3] = '{count:1, data:32'h0000_0042, ack_w:19, ack_start:0, dm2:8'h5A, hold:0, ed:8'h5A, et:0};
    tbl[4] = '{count:0, data:32'h0000_0000, ack_w:4,  ack_start:1, dm2:8'h11, hold:1, ed:8'h11, et:0};
    tbl[5] = '{count:0, data:32'hDEAD_BEEF, ack_w:0,  ack_start:0, dm2:8'h22, hold:0, ed:8'h22, et:0};
    tbl[6] = '{count:7, data:32'hA4A3_A2A1, ack_w:2,  ack_start:0, dm2:8'h99, hold:0, ed:8'hA3, et:0};

    repeat (3) @(negedge Clk);
    chk("rst_req_ready", Req_Ready, 0);
    chk("rst_dm_we", Dm_We, 0);
    chk("rst_dm_addr", Dm_Addr, 0);
    chk("rst_dm_wdata", Dm_Wdata, 0);
    chk("rst_cpu_start", Cpu_Start, 0);
    chk("rst_rsp_valid", Rsp_Valid, 0);
    chk("rst_rsp_data", Rsp_Data, 0);
    chk("rst_rsp_timeout", Rsp_Timeout, 0);
    chk("rst_busy", Busy, 0);
    Reset = 1'b1;
    @(negedge Clk);
    chk("post_rst_req_ready", Req_Ready, 1);

    for (int i = 0; i < 7; i++) begin
      run_job(tbl[i], tbl[i].ed, tbl[i].et);
    end

    // Reset pulled low in the second LOAD cycle of a 4-operand job.
    preload(1, 8'hEE);
    @(negedge Clk);
    Req_Valid = 1'b1; Req_Count = 3'd4; Req_Data = 32'h4433_2211;
    @(negedge Clk);
    Req_Valid = 1'b0;
    @(negedge Clk);
    chk("mid_load_we", Dm_We, 1);
    Reset = 1'b0;
    #1;
    chk("async_dm_we", Dm_We, 0);
    chk("async_cpu_start", Cpu_Start, 0);
    chk("async_busy", Busy, 0);
    chk("async_req_ready", Req_Ready, 0);
    chk("async_dm_addr", Dm_Addr, 0);
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    chk("rerst_req_ready", Req_Ready, 1);
    chk("rerst_cpu_start", Cpu_Start, 0);
    chk("kept_dm0", mem[0], 8'h11);
    chk("kept_dm1", mem[1], 8'hEE);

    for (int j = 0; j < 30; j++) begin
      v.count     = $urandom_range(0, 7);
      v.data      = $urandom;
      w           = $urandom_range(0, 24);
      v.ack_w     = (w >= TO) ? -1 : w;
      v.ack_start = ($urandom_range(0, 3) == 0);
      v.dm2       = $urandom_range(0, 255);
      v.hold      = $urandom_range(0, 3);
      v.ed        = 0;
      v.et        = 0;
      model(v, ed, et);
      run_job(v, ed, et);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
